spi_seg_regs: RTL and testbench



---
 rtl/spi_seg_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_seg_regs.sv | 172 +++++++++++++++++
 tb/tb_spi_seg_regs.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seg_pkg.sv
// Shared types and constants for the SPI 7-segment register bank.
// Holds the frame FSM states, fixed register addresses and command-byte fields.
package spi_seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } spi_state_t;

   localparam logic [6:0] ADDR_COLON = 7'h7E;
   localparam logic [6:0] ADDR_ID    = 7'h7F;

   localparam int CMD_RNW_BIT  = 7;
   localparam int CMD_ADDR_MSB = 6;
   localparam int CMD_ADDR_LSB = 0;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with rise/fall detect against a third flop.
// Latency: 2 clk to o_sync, events are combinational off o_sync; no backpressure.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_seg_regs.sv
// SPI mode-0 slave register bank for an N-digit 7-segment display; 3 clk pin-to-event, writes land 1 clk later.
// No backpressure: host paces via sclk. SPI_SEG_AUTOINC_EN enables address auto-increment per data byte.
module spi_seg_regs
   import spi_seg_pkg::*;
#(
   parameter int         NUM_DIGITS = 4,
   parameter logic [7:0] ID_VALUE   = 8'hA5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    spi_sclk,
   input  logic                    spi_cs_n,
   input  logic                    spi_mosi,
   output logic                    spi_miso,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [1:0]              colon,
   output logic                    wr_pulse,
   output logic                    frame_err
);

   logic w_sclk_lvl_unused, w_sclk_rise, w_sclk_fall;
   logic w_cs_lvl_unused, w_cs_rise, w_cs_fall;
   logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .i_async(spi_sclk),
      .o_sync(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .i_async(spi_cs_n),
      .o_sync(w_cs_lvl_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .i_async(spi_mosi),
      .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
   );

   spi_state_t                r_state, w_state_nxt;
   logic [2:0]                r_bit_cnt;
   logic [6:0]                r_rx;
   logic [7:0]                r_tx;
   logic [6:0]                r_addr;
   logic                      r_rnw;
   logic                      r_reload;
   logic [4*NUM_DIGITS-1:0]   r_digits;
   logic [1:0]                r_colon;
   logic                      r_wr_pulse;
   logic                      r_frame_err;

   logic [7:0] w_rx_byte;
   logic [7:0] w_rdback;
   logic       w_addr_wr_ok;
   logic       w_shift_in, w_shift_out, w_byte_done;
   logic       w_latch_cmd, w_commit, w_frame_err;

   assign w_rx_byte = {r_rx, w_mosi};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_in  = 1'b0;
      w_shift_out = 1'b0;
      w_byte_done = 1'b0;
      w_latch_cmd = 1'b0;
      w_commit    = 1'b0;
      w_frame_err = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) w_state_nxt = ST_CMD;
         end
         ST_CMD, ST_DATA: begin
            w_shift_in  = w_sclk_rise;
            // The fall right after a completed byte must not shift: the reload already put the new MSB on top.
            w_shift_out = w_sclk_fall && (r_bit_cnt != 3'd0);
            w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
            if (r_state == ST_CMD) begin
               if (w_byte_done) begin
                  w_latch_cmd = 1'b1;
                  w_state_nxt = ST_DATA;
               end
            end else begin
               w_commit = w_byte_done && !r_rnw && w_addr_wr_ok;
            end
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
               w_frame_err = (r_bit_cnt != 3'd0) && !w_byte_done;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rdback     = 8'h00;
      w_addr_wr_ok = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_addr == 7'(i)) begin
            w_rdback     = {4'h0, r_digits[4*i +: 4]};
            w_addr_wr_ok = 1'b1;
         end
      end
      if (r_addr == ADDR_COLON) begin
         w_rdback     = {6'h00, r_colon};
         w_addr_wr_ok = 1'b1;
      end
      if (r_addr == ADDR_ID) w_rdback = ID_VALUE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt   <= 3'd0;
         r_rx        <= 7'd0;
         r_tx        <= 8'd0;
         r_addr      <= 7'd0;
         r_rnw       <= 1'b0;
         r_reload    <= 1'b0;
         r_digits    <= '0;
         r_colon     <= 2'b11;
         r_wr_pulse  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_pulse  <= w_commit;
         r_frame_err <= w_frame_err;
         // Readback is taken one clk after a byte so it sees the latched address and committed data.
         r_reload    <= w_byte_done && !w_cs_rise;

         if (r_state == ST_IDLE) begin
            if (w_cs_fall) begin
               r_bit_cnt <= 3'd0;
               r_tx      <= ID_VALUE;
            end
         end else begin
            if (w_shift_in) begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               r_rx      <= w_rx_byte[6:0];
            end
            if (w_cs_rise) r_bit_cnt <= 3'd0;
            if (r_reload)         r_tx <= w_rdback;
            else if (w_shift_out) r_tx <= {r_tx[6:0], 1'b0};
         end

         if (w_latch_cmd) begin
            r_rnw  <= w_rx_byte[CMD_RNW_BIT];
            r_addr <= w_rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
         end

         if (w_commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (r_addr == 7'(i)) r_digits[4*i +: 4] <= w_rx_byte[3:0];
            end
            if (r_addr == ADDR_COLON) r_colon <= w_rx_byte[1:0];
         end

`ifdef SPI_SEG_AUTOINC_EN
         if (r_state == ST_DATA && w_byte_done) r_addr <= r_addr + 7'd1;
`endif
      end
   end

   assign spi_miso  = (r_state != ST_IDLE) && r_tx[7];
   assign digits    = r_digits;
   assign colon     = r_colon;
   assign wr_pulse  = r_wr_pulse;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_seg_regs.sv
// Directed bench for spi_seg_regs: bit-banged SPI frames with hand-computed expectations.
module tb_spi_seg_regs;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic [15:0] digits;
   logic [1:0]  colon;
   logic        wr_pulse;
   logic        frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt   = 0;
   int ferr_cnt = 0;

   logic [7:0] tx_bytes [8];
   logic [7:0] rx_bytes [8];

   spi_seg_regs #(.NUM_DIGITS(4), .ID_VALUE(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
      .spi_miso(miso), .digits(digits), .colon(colon), .wr_pulse(wr_pulse), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_pulse === 1'b1)  wr_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = b[i];
         wait_clk(HALF);
         r[i] = miso;
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic run_frame(input int n);
      logic [7:0] r;
      cs_n = 1'b0;
      wait_clk(HALF);
      for (int k = 0; k < n; k++) begin
         xfer_bits(tx_bytes[k], 8, r);
         rx_bytes[k] = r;
      end
      wait_clk(HALF);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(12);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      cs_n  = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(6);
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (digits !== 16'h0000) begin n_errors++; $display("FAIL reset_digits: got %h want 0000", digits); end
      n_checks++; if (colon !== 2'b11) begin n_errors++; $display("FAIL reset_colon: got %b want 11", colon); end
      n_checks++; if (miso !== 1'b0) begin n_errors++; $display("FAIL reset_miso: got %b want 0", miso); end
      n_checks++; if (wr_pulse !== 1'b0) begin n_errors++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
      n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
   endtask

   task automatic test_write_digit();
      int base;
      base = wr_cnt;
      tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h07;
      run_frame(2);
      n_checks++; if (digits !== 16'h0700) begin n_errors++; $display("FAIL write_digit: got %h want 0700", digits); end
      n_checks++; if (wr_cnt - base !== 1) begin n_errors++; $display("FAIL write_digit_pulses: got %0d want 1", wr_cnt - base); end
      n_checks++; if (rx_bytes[0] !== 8'hA5) begin n_errors++; $display("FAIL write_cmd_miso: got %h want a5", rx_bytes[0]); end
      base = wr_cnt;
      tx_bytes[0] = 8'h82; tx_bytes[1] = 8'h00;
      run_frame(2);
      n_checks++; if (rx_bytes[1] !== 8'h07) begin n_errors++; $display("FAIL readback_digit: got %h want 07", rx_bytes[1]); end
      n_checks++; if (wr_cnt - base !== 0) begin n_errors++; $display("FAIL read_no_pulse: got %0d want 0", wr_cnt - base); end
   endtask

   task automatic test_read_id();
      tx_bytes[0] = 8'hFF; tx_bytes[1] = 8'h00;
      run_frame(2);
      n_checks++; if (rx_bytes[0] !== 8'hA5) begin n_errors++; $display("FAIL read_id_cmd: got %h want a5", rx_bytes[0]); end
      n_checks++; if (rx_bytes[1] !== 8'hA5) begin n_errors++; $display("FAIL read_id_data: got %h want a5", rx_bytes[1]); end
   endtask

   task automatic test_colon();
      tx_bytes[0] = 8'h7E; tx_bytes[1] = 8'hFD;
      run_frame(2);
      n_checks++; if (colon !== 2'b01) begin n_errors++; $display("FAIL colon_write: got %b want 01", colon); end
      tx_bytes[0] = 8'hFE; tx_bytes[1] = 8'h00;
      run_frame(2);
      n_checks++; if (rx_bytes[1] !== 8'h01) begin n_errors++; $display("FAIL colon_read: got %h want 01", rx_bytes[1]); end
   endtask

   task automatic test_unmapped();
      int base;
      base = wr_cnt;
      tx_bytes[0] = 8'h40; tx_bytes[1] = 8'h55;
      run_frame(2);
      n_checks++; if (digits !== 16'h0700) begin n_errors++; $display("FAIL unmapped_digits: got %h want 0700", digits); end
      n_checks++; if (colon !== 2'b01) begin n_errors++; $display("FAIL unmapped_colon: got %b want 01", colon); end
      n_checks++; if (wr_cnt - base !== 0) begin n_errors++; $display("FAIL unmapped_pulse: got %0d want 0", wr_cnt - base); end
      tx_bytes[0] = 8'hC0; tx_bytes[1] = 8'h00;
      run_frame(2);
      n_checks++; if (rx_bytes[1] !== 8'h00) begin n_errors++; $display("FAIL unmapped_read: got %h want 00", rx_bytes[1]); end
   endtask

   // Last sclk rise and CS rise land on the same clk: byte commits, no frame error.
   task automatic test_back_to_back();
      int base_wr, base_fe;
      logic [7:0] r;
      base_wr = wr_cnt;
      base_fe = ferr_cnt;
      cs_n = 1'b0;
      wait_clk(HALF);
      xfer_bits(8'h03, 8, r);
      xfer_bits(8'h05, 7, r);
      mosi = 1'b1;
      wait_clk(HALF);
      sclk = 1'b1;
      cs_n = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      mosi = 1'b0;
      wait_clk(12);
      n_checks++; if (digits !== 16'h5700) begin n_errors++; $display("FAIL coincident_digits: got %h want 5700", digits); end
      n_checks++; if (wr_cnt - base_wr !== 1) begin n_errors++; $display("FAIL coincident_pulse: got %0d want 1", wr_cnt - base_wr); end
      n_checks++; if (ferr_cnt - base_fe !== 0) begin n_errors++; $display("FAIL coincident_ferr: got %0d want 0", ferr_cnt - base_fe); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] r;
      int base_fe;
      cs_n = 1'b0;
      wait_clk(HALF);
      xfer_bits(8'h01, 3, r);
      rst_n = 1'b0;
      wait_clk(1);
      n_checks++; if (digits !== 16'h0000) begin n_errors++; $display("FAIL midreset_digits: got %h want 0000", digits); end
      n_checks++; if (colon !== 2'b11) begin n_errors++; $display("FAIL midreset_colon: got %b want 11", colon); end
      n_checks++; if (miso !== 1'b0) begin n_errors++; $display("FAIL midreset_miso: got %b want 0", miso); end
      cs_n = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      wait_clk(3);
      base_fe = ferr_cnt;
      rst_n = 1'b1;
      wait_clk(6);
      tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h09;
      run_frame(2);
      n_checks++; if (digits !== 16'h0090) begin n_errors++; $display("FAIL midreset_next_frame: got %h want 0090", digits); end
      n_checks++; if (ferr_cnt - base_fe !== 0) begin n_errors++; $display("FAIL midreset_ferr: got %0d want 0", ferr_cnt - base_fe); end
   endtask

   task automatic test_abort();
      logic [7:0] r;
      int base_wr, base_fe;
      base_wr = wr_cnt;
      base_fe = ferr_cnt;
      cs_n = 1'b0;
      wait_clk(HALF);
      xfer_bits(8'h7E, 8, r);
      xfer_bits(8'h00, 5, r);
      wait_clk(HALF);
      cs_n = 1'b1;
      wait_clk(12);
      n_checks++; if (ferr_cnt - base_fe !== 1) begin n_errors++; $display("FAIL abort_ferr: got %0d want 1", ferr_cnt - base_fe); end
      n_checks++; if (colon !== 2'b11) begin n_errors++; $display("FAIL abort_colon: got %b want 11", colon); end
      n_checks++; if (wr_cnt - base_wr !== 0) begin n_errors++; $display("FAIL abort_pulse: got %0d want 0", wr_cnt - base_wr); end
      n_checks++; if (miso !== 1'b0) begin n_errors++; $display("FAIL abort_miso_idle: got %b want 0", miso); end
   endtask

   task automatic test_burst();
      int base;
      logic [15:0] exp_digits;
      logic [31:0] exp_rd;
`ifdef SPI_SEG_AUTOINC_EN
      exp_digits = 16'h4321;
      exp_rd     = 32'h01020304;
`else
      exp_digits = 16'h0004;
      exp_rd     = 32'h04040404;
`endif
      apply_reset();
      base = wr_cnt;
      tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h01; tx_bytes[2] = 8'h02;
      tx_bytes[3] = 8'h03; tx_bytes[4] = 8'h04;
      run_frame(5);
      n_checks++; if (digits !== exp_digits) begin n_errors++; $display("FAIL burst_digits: got %h want %h", digits, exp_digits); end
      n_checks++; if (wr_cnt - base !== 4) begin n_errors++; $display("FAIL burst_pulses: got %0d want 4", wr_cnt - base); end
      tx_bytes[0] = 8'h80; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00;
      tx_bytes[3] = 8'h00; tx_bytes[4] = 8'h00;
      run_frame(5);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rx_bytes[k+1] !== exp_rd[31-8*k -: 8]) begin
            n_errors++;
            $display("FAIL burst_read%0d: got %h want %h", k, rx_bytes[k+1], exp_rd[31-8*k -: 8]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_digit();
      test_read_id();
      test_colon();
      test_unmapped();
      test_back_to_back();
      test_reset_midframe();
      test_abort();
      test_burst();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
